rcc_dom_rst_seq: RTL and testbench
==================================

# rcc_dom_rst_seq

Parametrised multi-domain reset/clock-enable sequencer for the RCC vcore. It generalises the fixed per-domain reset-duration and clock-on-after-release counters into NUM_CH identical channels, each with its own state machine. Durations are runtime-programmable, and an optional ordered-release mode cascades resets down the chain. The block sits between rcc_reg (config, request and status) and the domain clock gates and reset synchronisers.

## Interface
- NUM_CH, 4, number of reset domains; channel 0 is the highest in the dependency chain.
- CNT_W, 8, width of the duration counters and config fields.
- RST_DURATION, 10, rst_n low cycles for the power-on sequence.
- CLK_ON_DELAY, 8, clk_en low cycles after rst_n release for the power-on sequence.
- SEQ_MODE, 1, 1 = channel i>0 releases only after channel i-1 has released, and cascades resets from i-1; 0 = channels fully independent.

Ports:
- hclk  in  1  single clock; all logic is on its rising edge.
- hresetn  in  1  reset, synchronous and active-low.
- rst_req  in  NUM_CH  level reset request per channel.
- cfg_rst_dur  in  NUM_CH*CNT_W  per-channel rst_n low duration; field i is bits [i*CNT_W +: CNT_W].
- cfg_clk_dly  in  NUM_CH*CNT_W  per-channel clk_en delay after release; same packing.
- dom_rst_n  out  NUM_CH  domain reset, active-low, registered.
- dom_clk_en  out  NUM_CH  domain clock enable, registered.
- dom_busy  out  NUM_CH  1 when the channel is not in RUN.
- dom_done  out  NUM_CH  one-cycle pulse on the CLKOFF->RUN transition.

## Operation
- Channel states:
  - RUN: rst_n=1, clk_en=1.
  - GATE: rst_n=1, clk_en=0; lasts exactly 1 cycle.
  - HOLD: rst_n=0, clk_en=0; counts D cycles.
  - WAIT_DEP: rst_n=0, clk_en=0.
  - CLKOFF: rst_n=1, clk_en=0; counts C cycles.
- Effective request: req_i = rst_req[i] | (SEQ_MODE && i>0 && channel i-1 in GATE). A single request on channel 0 therefore cascades to all channels, one cycle apart.
- Transitions:
  - RUN, req_i -> GATE.
  - GATE -> HOLD unconditionally. Load cnt with max(cfg_rst_dur[i],1).
  - HOLD: while req_i=1, reload cnt, so reset is extended for as long as the request is held.
  - HOLD -> WAIT_DEP or CLKOFF when cnt==1 and req_i=0.
  - WAIT_DEP -> CLKOFF when not SEQ_MODE, or i==0, or dom_rst_n[i-1]==1 (registered value). WAIT_DEP is transient when no dependency blocks.
  - On entry to CLKOFF, load cnt with cfg_clk_dly[i]. If cfg_clk_dly[i]==0, go directly to RUN in the same transition: rst_n and clk_en rise together and dom_done pulses.
  - CLKOFF -> RUN when cnt==1. dom_done[i]=1 for that one cycle.
  - CLKOFF, req_i -> HOLD. Reload the duration; clk_en stays 0 and rst_n drops next cycle.
  - GATE ignores req changes.
- cfg fields are sampled only at counter load. A change in mid-count does not affect the current count.
- Counters decrement by 1 per cycle and never wrap below 1. A cfg value of 0 for rst_dur is treated as 1.

## Timing
- Synchronous reset (hresetn=0 at an edge), all channels:
  - state=HOLD, cnt=max(RST_DURATION,1).
  - dom_rst_n=0, dom_clk_en=0, dom_busy=1, dom_done=0.
- The power-on sequence uses the parameters, not cfg:
  - The HOLD exit loads CLK_ON_DELAY instead of cfg_clk_dly.
  - A flag per channel, cleared on the first RUN entry, selects the parameters over cfg.
- hresetn asserted mid-sequence: every channel returns to its reset state on the next edge, regardless of its current state.
- Request latency, rst_req[i] sampled high at edge t while in RUN:
  - dom_clk_en falls after edge t.
  - dom_rst_n falls after edge t+1.
  - dom_rst_n stays low for exactly D cycles after rst_req drops. Cycles with req high do not count.
- All outputs change only at hclk edges. There are no combinational paths from inputs to outputs.

## Test plan
- Power-on, SEQ_MODE=1, defaults: after hresetn rises, dom_rst_n[0] rises at cycle 10 and dom_rst_n[1..3] at cycles 11/12/13. Each dom_clk_en rises 8 cycles after its rst_n. dom_done pulses once per channel.
- SEQ_MODE=0, cfg_rst_dur[2]=5, cfg_clk_dly[2]=3, single-cycle rst_req[2] pulse: clk_en[2] falls at +1, rst_n[2] is low for exactly 5 cycles, clk_en[2] rises 3 cycles after rst_n. The other channels do not change.
- rst_req[1] held for 20 cycles with cfg_rst_dur[1]=4: rst_n[1] stays low throughout and rises 4 cycles after the request drops.
- SEQ_MODE=1, 1-cycle rst_req[0] pulse with cfg_rst_dur[0]=20 and cfg_rst_dur[3]=2: GATE cascades to channels 1..3 at +1/+2/+3. Channel 3 sits in WAIT_DEP and releases one cycle after channel 2, never before channel 0.
- Re-request during CLKOFF (cfg_clk_dly=10, rst_req after 4 CLKOFF cycles): rst_n drops on the next cycle, clk_en never rises, and dom_done does not pulse until the full new sequence completes. cfg_clk_dly=0: rst_n and clk_en rise on the same edge.
- hresetn pulsed low for 1 cycle while channel 1 is in CLKOFF: all channels show rst_n=0 and clk_en=0 on the next cycle, then the full power-on sequence replays with parameter durations.

Source files
------------

// File: rtl/rcc_dom_rst_seq.sv
// rcc_dom_rst_seq: per-domain reset / clock-enable sequencer.
// NUM_CH identical channels. Each channel holds its domain in reset for a
// programmable number of cycles. It then releases reset and keeps the domain
// clock gated for a further programmable delay. With SEQ_MODE set, a reset on
// channel i-1 cascades to channel i, and channel i is released only after
// channel i-1 has released.
module rcc_dom_rst_seq #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 8,
    parameter int RST_DURATION = 10,
    parameter int CLK_ON_DELAY = 8,
    parameter int SEQ_MODE     = 1
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic [NUM_CH-1:0]       rst_req,
    input  logic [NUM_CH*CNT_W-1:0] cfg_rst_dur,
    input  logic [NUM_CH*CNT_W-1:0] cfg_clk_dly,
    output logic [NUM_CH-1:0]       dom_rst_n,
    output logic [NUM_CH-1:0]       dom_clk_en,
    output logic [NUM_CH-1:0]       dom_busy,
    output logic [NUM_CH-1:0]       dom_done
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_GATE,
        ST_HOLD,
        ST_WAIT_DEP,
        ST_CLKOFF
    } state_t;

    // Power-on durations. A zero reset duration is still held for one cycle.
    localparam logic [CNT_W-1:0] RST_DUR_P = (RST_DURATION < 1) ? CNT_W'(1) : CNT_W'(RST_DURATION);
    localparam logic [CNT_W-1:0] CLK_DLY_P = CNT_W'(CLK_ON_DELAY);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    // One bit per channel: that channel is in GATE. The next channel down
    // the chain uses it as a cascaded request.
    logic [NUM_CH-1:0] in_gate;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             por_q, por_d;       // still in power-on sequence: use parameters
        logic             rst_n_q, rst_n_d;
        logic             clk_en_q, clk_en_d;
        logic             done_q, done_d;
        logic             req;                // effective request incl. cascade
        logic             dep_ok;             // upstream domain already out of reset
        logic [CNT_W-1:0] cfg_dur;
        logic [CNT_W-1:0] dur_sel;
        logic [CNT_W-1:0] dly_sel;

        if (gi == 0) begin : g_head
            assign req    = rst_req[gi];
            assign dep_ok = 1'b1;
        end else begin : g_tail
            assign req    = rst_req[gi] | ((SEQ_MODE != 0) & in_gate[gi-1]);
            assign dep_ok = (SEQ_MODE == 0) | dom_rst_n[gi-1];
        end

        assign cfg_dur = cfg_rst_dur[gi*CNT_W +: CNT_W];
        assign dur_sel = por_q ? RST_DUR_P : ((cfg_dur == '0) ? ONE : cfg_dur);
        assign dly_sel = por_q ? CLK_DLY_P : cfg_clk_dly[gi*CNT_W +: CNT_W];

        // Next state, counter and output values for this channel.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            done_d  = 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (req) state_d = ST_GATE;
                end
                ST_GATE: begin
                    state_d = ST_HOLD;
                    cnt_d   = dur_sel;
                end
                ST_HOLD: begin
                    if (req) begin
                        cnt_d = dur_sel;              // a held request keeps reset asserted
                    end else if (cnt_q != ONE) begin
                        cnt_d = cnt_q - ONE;
                    end else if (!dep_ok) begin
                        state_d = ST_WAIT_DEP;
                    end else if (dly_sel == '0) begin
                        state_d = ST_RUN;             // reset and clock released together
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_CLKOFF;
                        cnt_d   = dly_sel;
                    end
                end
                ST_WAIT_DEP: begin
                    if (dep_ok) begin
                        if (dly_sel == '0) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_CLKOFF;
                            cnt_d   = dly_sel;
                        end
                    end
                end
                ST_CLKOFF: begin
                    // A new request wins over a completing clock-off count.
                    if (req) begin
                        state_d = ST_HOLD;
                        cnt_d   = dur_sel;
                    end else if (cnt_q == ONE) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = RST_DUR_P;
                end
            endcase

            por_d    = (state_d == ST_RUN) ? 1'b0 : por_q;
            rst_n_d  = (state_d == ST_RUN) || (state_d == ST_GATE) || (state_d == ST_CLKOFF);
            clk_en_d = (state_d == ST_RUN);
        end

        // State, counter and registered outputs. Reset re-enters the power-on hold.
        always_ff @(posedge hclk) begin
            if (!hresetn) begin
                state_q  <= ST_HOLD;
                cnt_q    <= RST_DUR_P;
                por_q    <= 1'b1;
                rst_n_q  <= 1'b0;
                clk_en_q <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                por_q    <= por_d;
                rst_n_q  <= rst_n_d;
                clk_en_q <= clk_en_d;
                done_q   <= done_d;
            end
        end

        assign in_gate[gi]    = (state_q == ST_GATE);
        assign dom_rst_n[gi]  = rst_n_q;
        assign dom_clk_en[gi] = clk_en_q;
        assign dom_busy[gi]   = (state_q != ST_RUN);
        assign dom_done[gi]   = done_q;
    end

endmodule

// File: tb/tb_rcc_dom_rst_seq.sv
// Testbench for rcc_dom_rst_seq. Two instances share the stimulus: one
// sequenced (SEQ_MODE=1) and one independent (SEQ_MODE=0). A behavioural
// model tracks the remaining reset and clock-off cycles of every domain. The
// outputs of both instances are compared with the model on every cycle.
module tb_rcc_dom_rst_seq;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 8;
    localparam int RST_DUR = 10;
    localparam int CLK_DLY = 8;

    logic                    hclk = 1'b0;
    logic                    hresetn;
    logic [NUM_CH-1:0]       rst_req;
    logic [NUM_CH*CNT_W-1:0] cfg_rst_dur;
    logic [NUM_CH*CNT_W-1:0] cfg_clk_dly;
    logic [NUM_CH-1:0]       s_rst_n, s_clk_en, s_busy, s_done;
    logic [NUM_CH-1:0]       i_rst_n, i_clk_en, i_busy, i_done;

    rcc_dom_rst_seq #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RST_DURATION(RST_DUR),
                      .CLK_ON_DELAY(CLK_DLY), .SEQ_MODE(1)) u_seq (
        .hclk(hclk), .hresetn(hresetn), .rst_req(rst_req),
        .cfg_rst_dur(cfg_rst_dur), .cfg_clk_dly(cfg_clk_dly),
        .dom_rst_n(s_rst_n), .dom_clk_en(s_clk_en), .dom_busy(s_busy), .dom_done(s_done));

    rcc_dom_rst_seq #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RST_DURATION(RST_DUR),
                      .CLK_ON_DELAY(CLK_DLY), .SEQ_MODE(0)) u_ind (
        .hclk(hclk), .hresetn(hresetn), .rst_req(rst_req),
        .cfg_rst_dur(cfg_rst_dur), .cfg_clk_dly(cfg_clk_dly),
        .dom_rst_n(i_rst_n), .dom_clk_en(i_clk_en), .dom_busy(i_busy), .dom_done(i_done));

    always #5 hclk = ~hclk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_rst_cyc = 0;
    bit started = 1'b0;

    // Model, index k: 0 = sequenced instance, 1 = independent instance.
    // hold > 0 : reset asserted, that many cycles left (re-armed while requested)
    // off  > 0 : reset released, clock still off for that many cycles
    bit m_rstn [2][NUM_CH];
    bit m_clken[2][NUM_CH];
    bit m_gate [2][NUM_CH];
    bit m_wait [2][NUM_CH];
    bit m_done [2][NUM_CH];
    bit m_first[2][NUM_CH];
    int m_hold [2][NUM_CH];
    int m_off  [2][NUM_CH];
    int m_rise [2][NUM_CH];   // cycle of the latest rst_n rise
    int m_fall [2][NUM_CH];   // cycle of the latest rst_n fall
    int m_clkr [2][NUM_CH];   // cycle of the latest clk_en rise

    task automatic release_ch(input int k, input int i, input int dly);
        m_rstn[k][i] = 1'b1;
        if (dly == 0) begin
            m_clken[k][i] = 1'b1;
            m_done[k][i]  = 1'b1;
            m_first[k][i] = 1'b0;
        end else begin
            m_off[k][i] = dly;
        end
    endtask

    task automatic model_step(input int k);
        bit og[NUM_CH];
        bit orn[NUM_CH];
        bit seq;
        seq = (k == 0);
        for (int i = 0; i < NUM_CH; i++) begin
            og[i]  = m_gate[k][i];
            orn[i] = m_rstn[k][i];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            bit req, dep_ok, prev_rn, prev_ce;
            int dur, dly;
            prev_rn = m_rstn[k][i];
            prev_ce = m_clken[k][i];
            req     = rst_req[i] || (seq && i > 0 && og[(i > 0) ? i - 1 : 0]);
            dep_ok  = !seq || i == 0 || orn[(i > 0) ? i - 1 : 0];
            dur     = m_first[k][i] ? RST_DUR : int'(cfg_rst_dur[i*CNT_W +: CNT_W]);
            if (dur == 0) dur = 1;
            dly     = m_first[k][i] ? CLK_DLY : int'(cfg_clk_dly[i*CNT_W +: CNT_W]);
            m_done[k][i] = 1'b0;
            if (!hresetn) begin
                m_gate[k][i]  = 1'b0;
                m_wait[k][i]  = 1'b0;
                m_hold[k][i]  = RST_DUR;
                m_off[k][i]   = 0;
                m_rstn[k][i]  = 1'b0;
                m_clken[k][i] = 1'b0;
                m_first[k][i] = 1'b1;
            end else if (m_gate[k][i]) begin
                m_gate[k][i] = 1'b0;
                m_hold[k][i] = dur;
                m_rstn[k][i] = 1'b0;
            end else if (m_hold[k][i] > 0) begin
                if (req) m_hold[k][i] = dur;
                else if (m_hold[k][i] > 1) m_hold[k][i]--;
                else begin
                    m_hold[k][i] = 0;
                    if (dep_ok) release_ch(k, i, dly);
                    else m_wait[k][i] = 1'b1;
                end
            end else if (m_wait[k][i]) begin
                if (dep_ok) begin
                    m_wait[k][i] = 1'b0;
                    release_ch(k, i, dly);
                end
            end else if (m_off[k][i] > 0) begin
                if (req) begin
                    m_off[k][i]  = 0;
                    m_hold[k][i] = dur;
                    m_rstn[k][i] = 1'b0;
                end else if (m_off[k][i] == 1) begin
                    m_off[k][i]   = 0;
                    m_clken[k][i] = 1'b1;
                    m_done[k][i]  = 1'b1;
                    m_first[k][i] = 1'b0;
                end else begin
                    m_off[k][i]--;
                end
            end else if (req) begin
                m_gate[k][i]  = 1'b1;
                m_clken[k][i] = 1'b0;
            end
            if (!prev_rn && m_rstn[k][i])  m_rise[k][i] = cyc;
            if (prev_rn && !m_rstn[k][i])  m_fall[k][i] = cyc;
            if (!prev_ce && m_clken[k][i]) m_clkr[k][i] = cyc;
        end
    endtask

    // Advance the model on each rising edge, using the inputs the DUT sees there.
    always @(posedge hclk) begin
        cyc++;
        if (!hresetn) last_rst_cyc = cyc;
        model_step(0);
        model_step(1);
        started = 1'b1;
    end

    logic [NUM_CH-1:0] a_rn, a_ce, a_bz, a_dn, e_rn, e_ce, e_bz, e_dn;

    // Compare all outputs of both instances with the model, away from the edge.
    always @(negedge hclk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    a_rn = s_rst_n; a_ce = s_clk_en; a_bz = s_busy; a_dn = s_done;
                end else begin
                    a_rn = i_rst_n; a_ce = i_clk_en; a_bz = i_busy; a_dn = i_done;
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    e_rn[i] = m_rstn[k][i];
                    e_ce[i] = m_clken[k][i];
                    e_bz[i] = !(m_rstn[k][i] && m_clken[k][i]);
                    e_dn[i] = m_done[k][i];
                end
                n_cmp++;
                if ({a_rn, a_ce, a_bz, a_dn} !== {e_rn, e_ce, e_bz, e_dn}) begin
                    n_err++;
                    $display("FAIL cycle %0d %s: rst_n=%b clk_en=%b busy=%b done=%b, expected rst_n=%b clk_en=%b busy=%b done=%b",
                             cyc, (k == 0) ? "seq" : "ind", a_rn, a_ce, a_bz, a_dn, e_rn, e_ce, e_bz, e_dn);
                end
            end
        end
    end

    task automatic check_eq(input string name, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end else begin
            $display("check %s: got %0d ok", name, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    task automatic set_cfg(input int ch, input int dur, input int dly);
        cfg_rst_dur[ch*CNT_W +: CNT_W] = CNT_W'(dur);
        cfg_clk_dly[ch*CNT_W +: CNT_W] = CNT_W'(dly);
    endtask

    task automatic pulse(input int ch);
        rst_req[ch] = 1'b1;
        tick(1);
        rst_req[ch] = 1'b0;
    endtask

    int drop_cyc;
    int r1;

    initial begin
        hresetn = 1'b0;
        rst_req = '0;
        for (int i = 0; i < NUM_CH; i++) set_cfg(i, 3, 2);
        tick(3);
        // Reset state, taken straight from the outputs.
        check_eq("reset rst_n seq", int'(s_rst_n), 0);
        check_eq("reset clk_en seq", int'(s_clk_en), 0);
        check_eq("reset busy ind", int'(i_busy), 15);
        check_eq("reset done ind", int'(i_done), 0);
        hresetn = 1'b1;
        tick(30);

        // Power-on: parameter durations, staggered release in sequenced mode.
        for (int i = 0; i < NUM_CH; i++) begin
            check_eq($sformatf("poweron seq rst_n[%0d] rise", i), m_rise[0][i] - last_rst_cyc, 10 + i);
            check_eq($sformatf("poweron seq clk_en[%0d] delay", i), m_clkr[0][i] - m_rise[0][i], 8);
            check_eq($sformatf("poweron ind rst_n[%0d] rise", i), m_rise[1][i] - last_rst_cyc, 10);
        end

        // Single-cycle request on channel 2 with programmed durations.
        set_cfg(2, 5, 3);
        pulse(2);
        tick(15);
        check_eq("ind ch2 rst_n low cycles", m_rise[1][2] - m_fall[1][2], 5);
        check_eq("ind ch2 clk_en delay", m_clkr[1][2] - m_rise[1][2], 3);

        // Held request: reset is extended and released D cycles after the drop.
        set_cfg(1, 4, 2);
        rst_req[1] = 1'b1;
        tick(20);
        rst_req[1] = 1'b0;
        drop_cyc = cyc;
        tick(15);
        check_eq("ind ch1 release after drop", m_rise[1][1] - drop_cyc, 4);

        // Cascade from channel 0 with a long hold upstream.
        set_cfg(0, 20, 2);
        set_cfg(3, 2, 2);
        pulse(0);
        tick(35);
        check_eq("seq ch1 after ch0", m_rise[0][1] - m_rise[0][0], 1);
        check_eq("seq ch3 after ch2", m_rise[0][3] - m_rise[0][2], 1);
        check_eq("seq ch3 after ch0", m_rise[0][3] - m_rise[0][0], 3);

        // Re-request after 4 cycles of clock-off.
        set_cfg(0, 3, 10);
        pulse(0);
        tick(7);
        r1 = m_rise[1][0];
        pulse(0);
        tick(30);
        check_eq("ind ch0 clkoff cycles before re-request", m_fall[1][0] - r1, 4);
        check_eq("ind ch0 second hold", m_rise[1][0] - m_fall[1][0], 3);
        check_eq("ind ch0 clk_en delay", m_clkr[1][0] - m_rise[1][0], 10);

        // Zero clock delay: reset and clock release on the same edge.
        set_cfg(0, 3, 0);
        pulse(0);
        tick(10);
        check_eq("ind ch0 zero delay same edge", m_clkr[1][0] - m_rise[1][0], 0);

        // Reset pulse while channel 1 is in clock-off.
        set_cfg(1, 4, 10);
        pulse(1);
        tick(7);
        hresetn = 1'b0;
        tick(1);
        hresetn = 1'b1;
        check_eq("midseq reset rst_n seq", int'(s_rst_n), 0);
        check_eq("midseq reset clk_en ind", int'(i_clk_en), 0);
        check_eq("midseq reset rst_n ind", int'(i_rst_n), 0);
        tick(30);
        check_eq("replay ind ch1 rise", m_rise[1][1] - last_rst_cyc, 10);
        check_eq("replay ind ch1 clk_en delay", m_clkr[1][1] - m_rise[1][1], 8);
        check_eq("replay seq ch3 rise", m_rise[0][3] - last_rst_cyc, 13);

        // Random requests, configuration changes and occasional resets.
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 63) == 0)
                set_cfg($urandom_range(0, NUM_CH - 1), $urandom_range(0, 6), $urandom_range(0, 6));
            rst_req = ($urandom_range(0, 15) == 0) ? NUM_CH'($urandom) : '0;
            hresetn = ($urandom_range(0, 599) != 0);
            tick(1);
        end
        hresetn = 1'b1;
        rst_req = '0;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
